// File: rtl/inst_issue_queue.sv
// Instruction issue queue: buffers packed instructions in a FIFO and presents
// them one at a time to the control unit, each held for an opcode-specific time.
module inst_issue_queue #(
  parameter int OPCODE_BITS             = 4,
  parameter int ADDR_BITS               = 8,
  parameter int OPERAND_BITS            = 128,
  parameter int INST_BITS               = OPCODE_BITS + 2*ADDR_BITS + OPERAND_BITS,
  parameter int DEPTH                   = 16,
  parameter int IDLE_CYCLE              = 1,
  parameter int AXI_TO_UB_CYCLE         = 1,
  parameter int AXI_TO_WB_CYCLE         = 1,
  parameter int UB_TO_DATA_FIFO_CYCLE   = 2,
  parameter int UB_TO_WEIGHT_FIFO_CYCLE = 2,
  parameter int MAT_MUL_CYCLE           = 20,
  parameter int CNT_BITS                = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_valid,
  input  logic [INST_BITS-1:0] s_inst,
  output logic                 s_ready,
  input  logic                 halt,
  output logic [INST_BITS-1:0] instruction,
  output logic                 inst_start,
  output logic                 busy,
  output logic [CNT_BITS-1:0]  count,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HOLD_BITS = 16;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  logic [INST_BITS-1:0] mem_q [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic                 state_q, state_d;
  logic [HOLD_BITS-1:0] hold_q, hold_d;
  logic [INST_BITS-1:0] instruction_q, instruction_d;
  logic                 inst_start_q, inst_start_d;
  logic                 busy_q, busy_d;

  logic                 push, pop;
  logic [INST_BITS-1:0] head;

  // Counter is loaded with cycles-1; zero or unknown opcodes collapse to 1 cycle.
  function automatic logic [HOLD_BITS-1:0] hold_init(input logic [OPCODE_BITS-1:0] op);
    int c;
    case (op)
      OPCODE_BITS'(0): c = IDLE_CYCLE;
      OPCODE_BITS'(1): c = AXI_TO_UB_CYCLE;
      OPCODE_BITS'(2): c = AXI_TO_WB_CYCLE;
      OPCODE_BITS'(3): c = UB_TO_DATA_FIFO_CYCLE;
      OPCODE_BITS'(4): c = UB_TO_WEIGHT_FIFO_CYCLE;
      OPCODE_BITS'(5),
      OPCODE_BITS'(6): c = MAT_MUL_CYCLE;
      default:         c = 1;
    endcase
    if (c < 1) c = 1;
    return HOLD_BITS'(c - 1);
  endfunction

  assign full  = (count_q == CNT_BITS'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = s_valid && !full;
  assign pop   = !empty && !halt && ((state_q == ST_IDLE) || (hold_q == '0));

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    hold_d        = hold_q;
    instruction_d = instruction_q;
    inst_start_d  = 1'b0;
    busy_d        = busy_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_BITS'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_BITS'(1);
    end

    if (pop) begin
      rd_ptr_d      = (rd_ptr_q == PTR_BITS'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_BITS'(1);
      instruction_d = head;
      hold_d        = hold_init(head[INST_BITS-1 -: OPCODE_BITS]);
      inst_start_d  = 1'b1;
      busy_d        = 1'b1;
      state_d       = ST_ISSUE;
    end else if (state_q == ST_ISSUE) begin
      if (hold_q == '0) begin
        instruction_d = '0;
        busy_d        = 1'b0;
        state_d       = ST_IDLE;
      end else begin
        hold_d = hold_q - HOLD_BITS'(1);
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_inst;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      instruction_q <= '0;
      inst_start_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      hold_q        <= hold_d;
      instruction_q <= instruction_d;
      inst_start_q  <= inst_start_d;
      busy_q        <= busy_d;
    end
  end

  assign s_ready     = !full;
  assign instruction = instruction_q;
  assign inst_start  = inst_start_q;
  assign busy        = busy_q;
  assign count       = count_q;

endmodule

// File: tb/tb_inst_issue_queue.sv
// Scoreboard bench for inst_issue_queue: directed scenarios plus random traffic
// checked against a queue-level reference model.
module tb_inst_issue_queue;

  localparam int IB    = 148;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          s_valid = 1'b0;
  logic [IB-1:0] s_inst = '0;
  logic          halt = 1'b0;
  logic          s_ready;
  logic [IB-1:0] instruction;
  logic          inst_start;
  logic          busy;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  int checks = 0;
  int errors = 0;

  inst_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_inst(s_inst),
    .s_ready(s_ready), .halt(halt), .instruction(instruction),
    .inst_start(inst_start), .busy(busy), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int cycles_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2: return 1;
      4'd3, 4'd4:       return 2;
      4'd5, 4'd6:       return 20;
      default:          return 1;
    endcase
  endfunction

  function automatic logic [IB-1:0] mk(input int op, input int a, input int b);
    logic [IB-1:0] r;
    r = IB'({$urandom, $urandom, $urandom, $urandom, $urandom});
    r[IB-1 -: 4] = op[3:0];
    r[143:136]   = a[7:0];
    r[135:128]   = b[7:0];
    return r;
  endfunction

  // Reference model: pending list, current instruction and cycles remaining.
  logic [IB-1:0] mq [$];
  logic [IB-1:0] sbq [$];
  logic [IB-1:0] m_cur = '0;
  int            m_rem = 0;
  logic          m_busy = 1'b0;
  logic          m_start = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      sbq.delete();
      m_cur = '0; m_rem = 0; m_busy = 1'b0; m_start = 1'b0;
    end else begin
      int  pre;
      logic do_push;
      pre     = mq.size();
      do_push = s_valid && (pre < DEPTH);
      if (m_busy && m_rem > 1) begin
        m_rem--;
        m_start = 1'b0;
      end else if (pre > 0 && !halt) begin
        m_cur   = mq.pop_front();
        m_rem   = cycles_of(m_cur[IB-1 -: 4]);
        m_busy  = 1'b1;
        m_start = 1'b1;
      end else begin
        m_cur = '0; m_rem = 0; m_busy = 1'b0; m_start = 1'b0;
      end
      if (do_push) begin
        mq.push_back(s_inst);
        sbq.push_back(s_inst);
      end
    end
  end

  // Monitor: per-cycle status against the model, issued instructions against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("instruction", 160'(instruction), 160'(m_cur));
      chk("inst_start",  160'(inst_start),  160'(m_start));
      chk("busy",        160'(busy),        160'(m_busy));
      chk("count",       160'(count),       160'(mq.size()));
      chk("empty",       160'(empty),       160'(mq.size() == 0));
      chk("full",        160'(full),        160'(mq.size() == DEPTH));
      chk("s_ready",     160'(s_ready),     160'(mq.size() < DEPTH));
      if (inst_start) begin
        if (sbq.size() == 0) begin
          chk("issue_unexpected", 160'(1), 160'(0));
        end else begin
          logic [IB-1:0] e;
          e = sbq.pop_front();
          chk("issue_order", 160'(instruction), 160'(e));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [IB-1:0] i, input logic h);
    s_valid = v; s_inst = i; halt = h;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_instruction"}, 160'(instruction), 160'(0));
    chk({tag, "_busy"},        160'(busy),        160'(0));
    chk({tag, "_inst_start"},  160'(inst_start),  160'(0));
    chk({tag, "_count"},       160'(count),       160'(0));
    chk({tag, "_empty"},       160'(empty),       160'(1));
    chk({tag, "_full"},        160'(full),        160'(0));
    chk({tag, "_s_ready"},     160'(s_ready),     160'(1));
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1 reset_checks("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Single MAT_MUL
    step(1'b1, mk(5, 3, 0), 1'b0);
    idle(25);

    // Fill under halt, 17th push must be refused
    for (int a = 0; a <= 16; a++) step(1'b1, mk(1, a, 0), 1'b1);
    idle(22);

    // Mixed back-to-back
    step(1'b1, mk(3, 7, 1), 1'b1);
    step(1'b1, mk(6, 8, 2), 1'b0);
    idle(28);

    // Halt asserted during MAT_MUL with one entry queued
    step(1'b1, mk(5, 9, 3), 1'b0);
    step(1'b1, mk(1, 10, 4), 1'b0);
    idle(3);
    for (int k = 0; k < 25; k++) step(1'b0, '0, 1'b1);
    idle(5);

    // Reset mid-MAT_MUL with three entries queued
    step(1'b1, mk(5, 11, 0), 1'b0);
    step(1'b1, mk(2, 12, 0), 1'b0);
    step(1'b1, mk(3, 13, 0), 1'b0);
    step(1'b1, mk(4, 14, 0), 1'b0);
    idle(3);
    #2 reset_n = 1'b0;
    #1 reset_checks("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic v, h;
      v = ($urandom_range(0, 99) < 60);
      h = ($urandom_range(0, 99) < 10);
      step(v, mk($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255)), h);
    end
    idle(400);

    chk("drain_scoreboard", 160'(sbq.size()), 160'(0));
    chk("drain_model",      160'(mq.size()),  160'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_issue_queue.md
# inst_issue_queue

Instruction issue queue that sits directly upstream of the control unit in the systolic-array TPU. It accepts packed instructions from the host/AXI side through a valid/ready port and buffers them in a DEPTH-entry FIFO. It presents them one at a time on the `instruction` bus to the control unit. Each instruction is held for an opcode-specific number of cycles, and IDLE_INST is driven when nothing is pending.

## Interface
- OPCODE_BITS, 4, opcode field width; field occupies instruction MSBs
- ADDR_BITS, 8, width of each of ADDRA and ADDRB fields (ADDRA above ADDRB)
- OPERAND_BITS, 128, operand field width (16 x 8-bit lanes), occupies LSBs
- INST_BITS, OPCODE_BITS+2*ADDR_BITS+OPERAND_BITS (=148), packed instruction width
- DEPTH, 16, FIFO entries (power of two)
- IDLE_CYCLE / AXI_TO_UB_CYCLE / AXI_TO_WB_CYCLE, 1 / 1 / 1, hold cycles for opcodes 0 / 1 / 2
- UB_TO_DATA_FIFO_CYCLE / UB_TO_WEIGHT_FIFO_CYCLE, 2 / 2, hold cycles for opcodes 3 / 4
- MAT_MUL_CYCLE, 20, hold cycles for opcodes 5 (MAT_MUL_INST) and 6 (MAT_MUL_ACC_INST)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  host presents an instruction
- s_inst  in  INST_BITS  instruction to enqueue
- s_ready  out  1  queue can accept; equals !full
- halt  in  1  inhibit starting a new instruction
- instruction  out  INST_BITS  instruction to control unit (registered)
- inst_start  out  1  one-cycle pulse on first cycle of each issued instruction
- busy  out  1  an instruction is currently being held
- count  out  clog2(DEPTH+1)  entries queued (excludes instruction being held)
- full, empty  out  1 each  count==DEPTH / count==0

## Operation
- Push: entry written at rising edge when s_valid && s_ready; no push when full, even if a pop occurs the same edge.
- Pop/issue states: IDLE, ISSUE.
- IDLE: if !empty && !halt at edge, pop head into instruction. Load hold counter with cycles(opcode)-1, pulse inst_start, set busy, go to ISSUE. Otherwise instruction = all zeros (IDLE_INST).
- ISSUE: counter decrements each edge. When counter==0 at edge:
  - if !empty && !halt: pop next back-to-back, no bubble, with inst_start pulsed again.
  - else: instruction <= 0, busy <= 0, go to IDLE.
- Opcodes 7..15 and any parameter value of 0 use 1 hold cycle. Unknown opcodes are still issued verbatim.
- halt never truncates the instruction in flight; it only blocks the next pop.
- Simultaneous push and pop: count unchanged; both take effect.
- Pointers wrap modulo DEPTH; count is separate and saturates only via s_ready.
- FIFO storage is not reset; pointers, count and all outputs are reset.

## Timing
- Reset values (asynchronous, immediate): instruction=0, inst_start=0, busy=0, count=0, empty=1, full=0, s_ready=1.
- Reset mid-operation discards queue and held instruction; nothing is issued after release until new pushes.
- Latency: push at edge N into empty IDLE queue gives instruction valid from edge N+1 (push does not bypass the FIFO).
- Each instruction is held exactly cycles(opcode) clock periods; inst_start is high only during the first of them.
- count/full/empty/s_ready update on the same edge as push/pop.
- Pop with empty never occurs; push with full is ignored and does not corrupt state.

## Test plan
- Reset: pulse reset_n low for half a cycle → instruction=0, count=0, empty=1, s_ready=1, busy=0 immediately.
- Single MAT_MUL: push {opcode 5, ADDRA 3} at edge 0 → instruction valid for edges 1..20 (20 cycles), inst_start only at edge 1, instruction=0 and busy=0 from edge 21.
- Fill/ordering:
  - with halt=1, push AXI_TO_UB ADDRA 0..16 → count reaches 16, full=1, s_ready=0, entry 16 not accepted.
  - release halt → ADDRA 0..15 issued one per cycle with no bubbles, inst_start high every cycle, then IDLE.
- Mixed back-to-back: queue UB_TO_DATA_FIFO then MAT_MUL_ACC → 2 cycles of opcode 3, then 20 cycles of opcode 6, with inst_start at the cycle-1 and cycle-3 boundaries.
- Halt mid-instruction: assert halt at cycle 5 of MAT_MUL with 1 entry queued → MAT_MUL still ends after 20 cycles. instruction=0 until halt drops, then the next entry issues the following edge.
- Reset mid-MAT_MUL with 3 entries queued → instruction=0, count=0 asynchronously; after release no instruction is issued.
